// File: rtl/uart_cmd_handler.sv
// uart_cmd_handler: turns byte commands from a UART RX FIFO into 32-bit memory accesses and replies.
// Latency: the reply starts the cycle after MEM_WR (write) or MEM_WAIT (read); 4-byte replies stream one per cycle.
// Backpressure: tx_full stalls the reply without losing a byte; RX bytes wait in their FIFO while busy.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   rx_empty, r_data, rd_uart  receive FIFO head and pop strobe
//   tx_full, w_data, wr_uart   transmit FIFO push interface
//   mem_addr, mem_wdata, mem_we, mem_re, mem_rdata   single-port memory (read data one cycle after mem_re)
//   busy                       high whenever a command is in progress
module uart_cmd_handler #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 1_000_000,
   parameter int TO_W    = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_empty,
   input  logic [7:0]        r_data,
   output logic              rd_uart,
   input  logic              tx_full,
   output logic [7:0]        w_data,
   output logic              wr_uart,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, MEM_WAIT, SEND
   } state_t;

   localparam logic [7:0]      OP_W     = 8'h57;
   localparam logic [7:0]      OP_R     = 8'h52;
   localparam logic [7:0]      ACK      = 8'h06;
   localparam logic [7:0]      NAK      = 8'h15;
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

   state_t            state_q, state_d;
   logic              is_wr_q, is_wr_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rsp_q,   rsp_d;
   logic [1:0]        dcnt_q,  dcnt_d;   // data byte being assembled
   logic [1:0]        idx_q,   idx_d;    // reply byte being sent
   logic [1:0]        last_q,  last_d;   // index of the final reply byte
   logic [TO_W-1:0]   to_q,    to_d;

   always_comb begin
      state_d = state_q;
      is_wr_d = is_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rsp_d   = rsp_q;
      dcnt_d  = dcnt_q;
      idx_d   = idx_q;
      last_d  = last_q;
      to_d    = '0;
      rd_uart = 1'b0;
      wr_uart = 1'b0;
      w_data  = 8'h00;
      mem_we  = 1'b0;
      mem_re  = 1'b0;
      busy    = 1'b0;
      // Everything is forced quiet while reset is held, even before the state register clears.
      if (!reset) begin
         busy = (state_q != IDLE);
         unique case (state_q)
            IDLE: begin
               if (!rx_empty) begin
                  rd_uart = 1'b1;
                  if (r_data == OP_W || r_data == OP_R) begin
                     is_wr_d = (r_data == OP_W);
                     state_d = GET_ADDR;
                  end else begin
                     rsp_d   = {24'h0, NAK};
                     idx_d   = 2'd0;
                     last_d  = 2'd0;
                     state_d = SEND;
                  end
               end
            end
            GET_ADDR, GET_DATA: begin
               if (!rx_empty) begin
                  rd_uart = 1'b1;
                  if (state_q == GET_ADDR) begin
                     addr_d  = ADDR_W'(r_data);
                     dcnt_d  = 2'd0;
                     state_d = is_wr_q ? GET_DATA : MEM_RD;
                  end else begin
                     wdata_d[{dcnt_q, 3'b000} +: 8] = r_data;
                     dcnt_d = dcnt_q + 2'd1;
                     if (dcnt_q == 2'd3) state_d = MEM_WR;
                  end
               end else if (to_q >= TO_LIMIT) begin
                  // Abandon the partial command: no access, no reply.
                  state_d = IDLE;
               end else begin
                  to_d = (to_q == '1) ? to_q : to_q + 1'b1;
               end
            end
            MEM_WR: begin
               mem_we  = 1'b1;
               rsp_d   = {24'h0, ACK};
               idx_d   = 2'd0;
               last_d  = 2'd0;
               state_d = SEND;
            end
            MEM_RD: begin
               mem_re  = 1'b1;
               state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
               rsp_d   = mem_rdata;
               idx_d   = 2'd0;
               last_d  = 2'd3;
               state_d = SEND;
            end
            SEND: begin
               if (!tx_full) begin
                  wr_uart = 1'b1;
                  w_data  = rsp_q[{idx_q, 3'b000} +: 8];
                  if (idx_q == last_q) state_d = IDLE;
                  else                 idx_d   = idx_q + 2'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign mem_addr  = reset ? '0 : addr_q;
   assign mem_wdata = reset ? '0 : wdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         is_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rsp_q   <= '0;
         dcnt_q  <= '0;
         idx_q   <= '0;
         last_q  <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         is_wr_q <= is_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rsp_q   <= rsp_d;
         dcnt_q  <= dcnt_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         to_q    <= to_d;
      end
   end

endmodule

// File: tb/tb_uart_cmd_handler.sv
// Bench for uart_cmd_handler: a command-level model parses every popped byte into
// expected memory accesses and reply bytes; each cycle the DUT strobes are matched against it.
module tb_uart_cmd_handler;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_empty;
   logic [7:0]  r_data;
   logic        rd_uart;
   logic        tx_full;
   logic [7:0]  w_data;
   logic        wr_uart;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic        busy;

   always #5 clk = ~clk;

   uart_cmd_handler #(.ADDR_W(8), .TIMEOUT(16), .TO_W(5)) dut (
      .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
      .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Environment: RX FIFO contents, memory array, captured TX stream.
   logic [7:0]  rxq[$];
   logic [7:0]  tx_log[$];
   logic [31:0] env_mem[256];
   logic        rd_pend;
   logic [7:0]  rd_addr;
   int          stall_cnt, stall_seen, push_cnt;
   bit          stall_req;

   // Model: bytes of the command in progress and what it must produce.
   logic [7:0]  cur[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  exp_wa[$];
   logic [31:0] exp_wd[$];
   logic [7:0]  exp_ra[$];
   logic [31:0] model_mem[256];
   int          outstanding;
   int          n_we, n_re;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic model_pop(input logic [7:0] b);
      logic [31:0] d;
      cur.push_back(b);
      if (cur[0] != 8'h57 && cur[0] != 8'h52) begin
         exp_tx.push_back(8'h15);
         outstanding = 1;
         cur.delete();
      end else if (cur[0] == 8'h52 && cur.size() == 2) begin
         exp_ra.push_back(cur[1]);
         d = model_mem[cur[1]];
         for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
         outstanding = 4;
         cur.delete();
      end else if (cur[0] == 8'h57 && cur.size() == 6) begin
         d = {cur[5], cur[4], cur[3], cur[2]};
         exp_wa.push_back(cur[1]);
         exp_wd.push_back(d);
         model_mem[cur[1]] = d;
         exp_tx.push_back(8'h06);
         outstanding = 1;
         cur.delete();
      end
   endtask

   // One clock cycle: observe at the falling edge, update environment just after the rising edge.
   task automatic tick();
      bit popped;
      popped = 1'b0;
      @(negedge clk);
      if (reset) begin
         check("rst_rd_uart", rd_uart, 0);
         check("rst_wr_uart", wr_uart, 0);
         check("rst_mem_we", mem_we, 0);
         check("rst_mem_re", mem_re, 0);
         check("rst_busy", busy, 0);
         check("rst_w_data", w_data, 0);
         check("rst_mem_addr", mem_addr, 0);
         check("rst_mem_wdata", mem_wdata, 0);
      end else begin
         if (tx_full) stall_seen++;
         if (rd_uart) begin
            check("pop_nonempty", rx_empty, 0);
            check("pop_while_reply_pending", outstanding, 0);
            popped = 1'b1;
            model_pop(r_data);
         end
         if (mem_we) begin
            check("we_expected", exp_wa.size() != 0, 1);
            if (exp_wa.size() != 0) begin
               check("we_addr", mem_addr, exp_wa[0]);
               check("we_data", mem_wdata, exp_wd[0]);
               void'(exp_wa.pop_front());
               void'(exp_wd.pop_front());
            end
            env_mem[mem_addr] = mem_wdata;
            n_we++;
         end
         if (mem_re) begin
            check("re_expected", exp_ra.size() != 0, 1);
            if (exp_ra.size() != 0) begin
               check("re_addr", mem_addr, exp_ra[0]);
               void'(exp_ra.pop_front());
            end
            rd_pend = 1'b1;
            rd_addr = mem_addr;
            n_re++;
         end
         if (wr_uart) begin
            check("push_not_full", tx_full, 0);
            check("push_expected", exp_tx.size() != 0, 1);
            if (exp_tx.size() != 0) begin
               check("tx_byte", w_data, exp_tx[0]);
               void'(exp_tx.pop_front());
               outstanding--;
            end
            tx_log.push_back(w_data);
            push_cnt++;
            if (stall_req && push_cnt == 2) begin
               stall_cnt = 5;
               stall_req = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      if (popped) void'(rxq.pop_front());
      rx_empty  = (rxq.size() == 0);
      r_data    = rx_empty ? 8'h00 : rxq[0];
      mem_rdata = rd_pend ? env_mem[rd_addr] : 32'h0BAD_0BAD;
      rd_pend   = 1'b0;
      if (stall_cnt > 0) begin
         tx_full = 1'b1;
         stall_cnt--;
      end else begin
         tx_full = 1'b0;
      end
   endtask

   task automatic feed(input logic [7:0] b);
      rxq.push_back(b);
      rx_empty = 1'b0;
      r_data   = rxq[0];
   endtask

   task automatic wait_quiet(input int max);
      int n;
      n = 0;
      while (!(rxq.size() == 0 && cur.size() == 0 && outstanding == 0 && exp_wa.size() == 0 &&
               exp_ra.size() == 0 && busy == 1'b0) && n < max) begin
         tick();
         n++;
      end
      check("quiet_within_budget", n < max, 1);
   endtask

   task automatic check_reply4(input string name, input int base, input logic [31:0] word);
      check({name, "_len"}, tx_log.size(), base + 4);
      for (int i = 0; i < 4; i++)
         if (tx_log.size() > base + i) check(name, tx_log[base + i], word[8*i +: 8]);
   endtask

   task automatic model_clear();
      cur.delete();
      exp_tx.delete();
      exp_wa.delete();
      exp_wd.delete();
      exp_ra.delete();
      outstanding = 0;
   endtask

   initial begin
      int base, we0, re0;
      logic [7:0] bv;
      reset = 1'b1; rx_empty = 1'b1; r_data = 8'h00; tx_full = 1'b0; mem_rdata = 32'h0;
      rd_pend = 1'b0; rd_addr = 8'h00; stall_cnt = 0; stall_seen = 0; push_cnt = 0; stall_req = 1'b0;
      n_we = 0; n_re = 0; outstanding = 0;
      for (int i = 0; i < 256; i++) begin
         bv = 8'(i);
         env_mem[i]   = {4{bv}};
         model_mem[i] = {4{bv}};
      end
      tick(); tick();
      reset = 1'b0;
      tick();

      // Write 0xDEADBEEF to 0x10, expect ACK.
      base = tx_log.size(); we0 = n_we;
      feed(8'h57); feed(8'h10); feed(8'hEF); feed(8'hBE); feed(8'hAD); feed(8'hDE);
      wait_quiet(200);
      check("w_we_count", n_we - we0, 1);
      check("w_mem_word", env_mem[8'h10], 32'hDEADBEEF);
      check("w_ack_len", tx_log.size(), base + 1);
      if (tx_log.size() > base) check("w_ack", tx_log[base], 8'h06);

      // Read it back.
      base = tx_log.size(); re0 = n_re;
      feed(8'h52); feed(8'h10);
      wait_quiet(200);
      check("r_re_count", n_re - re0, 1);
      check_reply4("r_reply", base, 32'hDEADBEEF);

      // Read of an untouched word returns the preload pattern.
      base = tx_log.size();
      feed(8'h52); feed(8'h05);
      wait_quiet(200);
      check_reply4("r05_reply", base, 32'h05050505);

      // Unknown opcode gets NAK and no memory traffic.
      base = tx_log.size(); we0 = n_we; re0 = n_re;
      feed(8'h41);
      wait_quiet(200);
      check("nak_len", tx_log.size(), base + 1);
      if (tx_log.size() > base) check("nak_byte", tx_log[base], 8'h15);
      check("nak_no_mem", (n_we - we0) + (n_re - re0), 0);
      check("nak_busy_low", busy, 0);

      // TX backpressure for 5 cycles after the 2nd reply byte.
      base = tx_log.size(); push_cnt = 0; stall_req = 1'b1; stall_seen = 0;
      feed(8'h52); feed(8'h10);
      wait_quiet(200);
      check("stall_cycles", stall_seen, 5);
      check_reply4("stall_reply", base, 32'hDEADBEEF);

      // Inter-byte timeout aborts a partial write silently.
      base = tx_log.size(); we0 = n_we;
      feed(8'h57); feed(8'h10); feed(8'hAA);
      for (int i = 0; i < 10; i++) tick();
      check("to_still_busy", busy, 1);
      for (int i = 0; i < 12; i++) tick();
      check("to_idle", busy, 0);
      check("to_no_we", n_we - we0, 0);
      check("to_no_tx", tx_log.size(), base);
      cur.delete();
      feed(8'h52); feed(8'h10);
      wait_quiet(200);
      check_reply4("to_then_read", base, 32'hDEADBEEF);

      // Reset after the first byte of a read reply.
      base = tx_log.size();
      feed(8'h52); feed(8'h10);
      begin
         int n;
         n = 0;
         while (tx_log.size() < base + 1 && n < 100) begin
            tick();
            n++;
         end
         check("mid_reply_reached", n < 100, 1);
      end
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      model_clear();
      for (int i = 0; i < 6; i++) tick();
      check("rst_no_more_tx", tx_log.size(), base + 1);
      base = tx_log.size();
      feed(8'h52); feed(8'h10);
      wait_quiet(200);
      check_reply4("post_rst_read", base, 32'hDEADBEEF);

      // Two write commands queued back to back.
      base = tx_log.size(); we0 = n_we;
      feed(8'h57); feed(8'h20); feed(8'h44); feed(8'h33); feed(8'h22); feed(8'h11);
      feed(8'h57); feed(8'h21); feed(8'h0D); feed(8'hF0); feed(8'hFE); feed(8'hCA);
      wait_quiet(300);
      check("b2b_we_count", n_we - we0, 2);
      check("b2b_mem20", env_mem[8'h20], 32'h11223344);
      check("b2b_mem21", env_mem[8'h21], 32'hCAFEF00D);
      check("b2b_tx_len", tx_log.size(), base + 2);
      if (tx_log.size() > base + 1) begin
         check("b2b_ack0", tx_log[base], 8'h06);
         check("b2b_ack1", tx_log[base + 1], 8'h06);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_cmd_handler.md
UART_CMD_HANDLER -- requirements
Module: uart_cmd_handler

Interface
REQ-001 Parameter ADDR_W, 8, memory word-address width; the address is always carried in one byte, and the low ADDR_W bits are used.
REQ-002 Parameter TIMEOUT, 1_000_000, idle clock cycles allowed between bytes of one command before it is aborted.
REQ-003 Parameter TO_W, 20, width of the timeout counter; it SHALL satisfy 2^TO_W > TIMEOUT.
REQ-004 clk  input  1  single system clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx_empty  input  1  UART receive FIFO empty flag.
REQ-007 r_data  input  8  head byte of the receive FIFO; valid whenever rx_empty=0.
REQ-008 rd_uart  output  1  one-cycle pop strobe to the receive FIFO.
REQ-009 tx_full  input  1  UART transmit FIFO full flag.
REQ-010 w_data  output  8  byte pushed to the transmit FIFO.
REQ-011 wr_uart  output  1  one-cycle push strobe to the transmit FIFO.
REQ-012 mem_addr  output  ADDR_W  word address for the memory port.
REQ-013 mem_wdata  output  32  write data for the memory port.
REQ-014 mem_we  output  1  one-cycle write strobe.
REQ-015 mem_re  output  1  one-cycle read strobe; mem_rdata SHALL be valid on the cycle after mem_re.
REQ-016 mem_rdata  input  32  read data from the memory port.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 Command protocol:
- 0x57 'W' + addr + D0..D3 (little-endian) -> one memory write, then reply 0x06.
- 0x52 'R' + addr -> one memory read, then reply D0..D3 (little-endian).
- Any other first byte -> reply 0x15 (NAK).
REQ-019 FSM states: IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, MEM_WAIT, SEND, and the transitions between them are:
- IDLE -> GET_ADDR on opcode W or R.
- IDLE -> SEND (1-byte NAK) on any other opcode.
- GET_ADDR -> GET_DATA if the opcode is W; -> MEM_RD if the opcode is R.
- GET_DATA -> MEM_WR after the 4th data byte.
- MEM_WR -> SEND (1-byte ACK).
- MEM_RD -> MEM_WAIT.
- MEM_WAIT -> SEND (4 bytes).
- SEND -> IDLE after the last byte is pushed.
REQ-020 Receive-byte consumption:
- In IDLE, GET_ADDR and GET_DATA, when rx_empty=0, the block samples r_data and asserts rd_uart in the same cycle.
- At most one pop per cycle; rd_uart is never high when rx_empty=1 or in any other state.
REQ-021 Bytes arriving while the FSM is in MEM_*, or SEND SHALL remain in the receive FIFO, and SHALL be consumed only after the return to IDLE.
REQ-022 Data bytes SHALL be assembled as follows: Dn lands in mem_wdata[8n+7:8n], and mem_wdata holds its value until the next write command.
REQ-023 Write: mem_we SHALL pulse for exactly one cycle in MEM_WR, with mem_addr and mem_wdata stable during that cycle.
REQ-024 Read:
- mem_re pulses for exactly one cycle in MEM_RD.
- In MEM_WAIT, mem_rdata is captured into a 32-bit response register.
REQ-025 Reply transmission:
- In SEND, wr_uart=1 and w_data=current response byte only in cycles where tx_full=0.
- The byte index advances only on a push.
- When tx_full=1, wr_uart=0 and the index holds, with no byte lost or duplicated.
REQ-026 Throughput: the first reply byte SHALL be pushed no earlier than the cycle after MEM_WR (for W) or MEM_WAIT (for R); with tx_full=0 throughout, the 4-byte reply SHALL occupy 4 consecutive cycles.
REQ-027 Timeout counter:
- Clears on every pop and on entry to GET_ADDR.
- Increments each cycle spent in GET_ADDR or GET_DATA without a pop.
- On reaching TIMEOUT, the FSM returns to IDLE with no memory access and no reply.
REQ-028 The timeout counter SHALL saturate and never wrap, and it SHALL NOT run in IDLE, MEM_*, or SEND.
REQ-029 No memory strobe SHALL ever assert outside MEM_WR or MEM_RD.

Reset
REQ-030 While reset=1 (sampled on clk), the FSM SHALL go to IDLE.
REQ-031 While reset=1, the outputs SHALL take these values: rd_uart=0, wr_uart=0, mem_we=0, mem_re=0, busy=0, w_data=0x00, mem_addr=0, mem_wdata=0.
REQ-032 While reset=1, the byte index, the timeout counter and the response register SHALL be cleared.
REQ-033 Reset asserted mid-command or mid-reply SHALL abandon that command: the partial command is discarded, no further strobes occur, and the remaining reply bytes are not sent.

Verification
REQ-034 Write then read:
- rx 57 10 EF BE AD DE -> one mem_we with mem_addr=0x10 and mem_wdata=0xDEADBEEF; tx 06.
- Then rx 52 10 with memory returning 0xDEADBEEF -> one mem_re; tx EF BE AD DE.
REQ-035 Unknown opcode: rx 41 -> tx 15, with no mem_we or mem_re, and busy returns to 0.
REQ-036 TX backpressure: R reply with tx_full forced high for 5 cycles after the 2nd byte -> wr_uart=0 during the stall, and the bytes arrive exactly as 4 bytes in order.
REQ-037 Timeout (TIMEOUT=16):
- rx 57 10 AA, then silence for 16 cycles -> return to IDLE; no mem_we; no tx.
- Then rx 52 10 -> normal read reply.
REQ-038 Reset mid-reply: reset asserted after 1 of 4 reply bytes -> no further wr_uart pushes, all outputs at their reset values, and the next command is processed normally.
REQ-039 Back-to-back commands: two complete W commands preloaded in the rx FIFO -> two mem_we pulses and two 06 bytes, with no pop occurring during MEM_* or SEND.
